// File: rtl/sid_regbank_multi.sv
// Multi-bank SID register file: masked register writes, per-bank open-bus latch with
// tick-driven decay, and a registered read mux that serves the lowest selected bank.
module sid_regbank_multi #(
    parameter int          NUM_SID     = 2,
    parameter logic [15:0] DECAY_TICKS = 16'd2000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_1m,
    input  logic [NUM_SID-1:0]     cs,
    input  logic                   we,
    input  logic [4:0]             addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic [NUM_SID*8-1:0]   pot_x,
    input  logic [NUM_SID*8-1:0]   pot_y,
    input  logic [NUM_SID*8-1:0]   osc3,
    input  logic [NUM_SID*8-1:0]   env3,
    output logic [NUM_SID*200-1:0] regs,
    output logic [NUM_SID-1:0]     wr_stb,
    output logic [4:0]             wr_addr
);

    localparam logic [4:0] LAST_REG = 5'h18;

    logic [7:0]         r_regs   [NUM_SID][25];
    logic [7:0]         r_lastWr [NUM_SID];
    logic [15:0]        r_decay  [NUM_SID];
    logic [NUM_SID-1:0] r_wrStb;
    logic [4:0]         r_wrAddr;
    logic [7:0]         r_dataOut;

    logic [7:0]         w_wrData;
    logic [7:0]         w_readData;

    // Pulse-width high nibbles and the 3-bit filter cutoff low byte keep only their implemented bits.
    always_comb begin
        w_wrData = data_in;
        case (addr)
            5'h03, 5'h0A, 5'h11: w_wrData = {4'h0, data_in[3:0]};
            5'h15:               w_wrData = {5'h00, data_in[2:0]};
            default:             w_wrData = data_in;
        endcase
    end

    // Walking from the top bank down leaves the lowest selected bank as the one that is read.
    always_comb begin
        w_readData = 8'h00;
        for (int k = NUM_SID - 1; k >= 0; k--) begin
            if (cs[k]) begin
                case (addr)
                    5'h19:   w_readData = pot_x[k*8 +: 8];
                    5'h1A:   w_readData = pot_y[k*8 +: 8];
                    5'h1B:   w_readData = osc3[k*8 +: 8];
                    5'h1C:   w_readData = env3[k*8 +: 8];
                    default: w_readData = r_lastWr[k];
                endcase
            end
        end
    end

    // A write on the same edge as the final decay tick takes priority and restarts the decay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_SID; k++) begin
                for (int r = 0; r < 25; r++) begin
                    r_regs[k][r] <= 8'h00;
                end
                r_lastWr[k] <= 8'h00;
                r_decay[k]  <= 16'd0;
            end
            r_wrStb   <= '0;
            r_wrAddr  <= 5'h00;
            r_dataOut <= 8'h00;
        end else begin
            r_wrStb <= we ? cs : '0;
            if (we && (|cs)) begin
                r_wrAddr <= addr;
            end
            if (|cs) begin
                r_dataOut <= w_readData;
            end
            for (int k = 0; k < NUM_SID; k++) begin
                if (we && cs[k]) begin
                    if (addr <= LAST_REG) begin
                        r_regs[k][addr] <= w_wrData;
                    end
                    r_lastWr[k] <= data_in;
                    r_decay[k]  <= DECAY_TICKS;
                end else if (ce_1m && (r_decay[k] != 16'd0)) begin
                    r_decay[k] <= r_decay[k] - 16'd1;
                    if (r_decay[k] == 16'd1) begin
                        r_lastWr[k] <= 8'h00;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_SID; k++) begin : g_bank
        for (genvar r = 0; r < 25; r++) begin : g_reg
            assign regs[(k*25+r)*8 +: 8] = r_regs[k][r];
        end
    end

    assign data_out = r_dataOut;
    assign wr_stb   = r_wrStb;
    assign wr_addr  = r_wrAddr;

endmodule

// File: tb/tb_sid_regbank_multi.sv
// Directed bench for sid_regbank_multi with two banks and a three-tick decay.
module tb_sid_regbank_multi;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce_1m;
    logic [1:0]   cs;
    logic         we;
    logic [4:0]   addr;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic [15:0]  pot_x;
    logic [15:0]  pot_y;
    logic [15:0]  osc3;
    logic [15:0]  env3;
    logic [399:0] regs;
    logic [1:0]   wr_stb;
    logic [4:0]   wr_addr;

    logic [399:0] expRegs;
    int           compareCount = 0;
    int           mismatchCount = 0;

    sid_regbank_multi #(
        .NUM_SID     (2),
        .DECAY_TICKS (16'd3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_1m    (ce_1m),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .pot_x    (pot_x),
        .pot_y    (pot_y),
        .osc3     (osc3),
        .env3     (env3),
        .regs     (regs),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the rising edge for checking.
    task automatic applyStimulus(input logic [1:0] c, input logic w, input logic [4:0] a,
                                 input logic [7:0] d, input logic tick);
        cs      = c;
        we      = w;
        addr    = a;
        data_in = d;
        ce_1m   = tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [399:0] observed,
                               input logic [399:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setExp(input int bank, input int r, input logic [7:0] v);
        expRegs[(bank*25+r)*8 +: 8] = v;
    endtask

    initial begin
        reset   = 1'b1;
        expRegs = '0;
        pot_x   = {8'h22, 8'h11};
        pot_y   = {8'h44, 8'h33};
        osc3    = {8'h99, 8'h77};
        env3    = {8'hBB, 8'hAA};
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b0);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("reset_regs", regs, expRegs);
        checkOutput("reset_dout", 400'(data_out), 400'h00);
        checkOutput("reset_stb", 400'(wr_stb), 400'h0);
        checkOutput("reset_waddr", 400'(wr_addr), 400'h00);

        // Bank 1 write to a masked PW-hi register
        applyStimulus(2'b10, 1'b1, 5'h03, 8'hFF, 1'b0);
        setExp(1, 3, 8'h0F);
        checkOutput("b1_mask_regs", regs, expRegs);
        checkOutput("b1_stb", 400'(wr_stb), 400'h2);
        checkOutput("b1_waddr", 400'(wr_addr), 400'h03);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b0);
        checkOutput("b1_stb_drop", 400'(wr_stb), 400'h0);
        checkOutput("b1_waddr_hold", 400'(wr_addr), 400'h03);

        // Filter cutoff low keeps three bits
        applyStimulus(2'b01, 1'b1, 5'h15, 8'hFF, 1'b0);
        setExp(0, 21, 8'h07);
        checkOutput("fc_mask_regs", regs, expRegs);

        // Broadcast write then read of lowest bank
        applyStimulus(2'b11, 1'b1, 5'h18, 8'h1F, 1'b0);
        setExp(0, 24, 8'h1F);
        setExp(1, 24, 8'h1F);
        checkOutput("bcast_regs", regs, expRegs);
        checkOutput("bcast_stb", 400'(wr_stb), 400'h3);
        applyStimulus(2'b11, 1'b0, 5'h18, 8'h00, 1'b0);
        checkOutput("bcast_read", 400'(data_out), 400'h1F);

        // Unimplemented address only updates the latch
        applyStimulus(2'b01, 1'b1, 5'h1D, 8'h3C, 1'b0);
        checkOutput("hi_addr_regs", regs, expRegs);
        checkOutput("hi_addr_stb", 400'(wr_stb), 400'h1);
        checkOutput("hi_addr_waddr", 400'(wr_addr), 400'h1D);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("hi_addr_latch", 400'(data_out), 400'h3C);

        // Write strobe with no select does nothing
        applyStimulus(2'b00, 1'b1, 5'h00, 8'hAA, 1'b0);
        checkOutput("nocs_regs", regs, expRegs);
        checkOutput("nocs_stb", 400'(wr_stb), 400'h0);
        checkOutput("nocs_waddr", 400'(wr_addr), 400'h1D);
        checkOutput("nocs_dout_hold", 400'(data_out), 400'h3C);

        // Readback paths
        applyStimulus(2'b01, 1'b0, 5'h1B, 8'h00, 1'b0);
        checkOutput("osc3_b0", 400'(data_out), 400'h77);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b0);
        checkOutput("osc3_hold", 400'(data_out), 400'h77);
        applyStimulus(2'b10, 1'b0, 5'h19, 8'h00, 1'b0);
        checkOutput("potx_b1", 400'(data_out), 400'h22);
        applyStimulus(2'b11, 1'b0, 5'h1C, 8'h00, 1'b0);
        checkOutput("env3_b0", 400'(data_out), 400'hAA);
        applyStimulus(2'b10, 1'b0, 5'h1A, 8'h00, 1'b0);
        checkOutput("poty_b1", 400'(data_out), 400'h44);

        // Read during write returns pre-write latch
        applyStimulus(2'b01, 1'b1, 5'h1E, 8'hC3, 1'b0);
        checkOutput("rdwr_pre", 400'(data_out), 400'h3C);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("rdwr_post", 400'(data_out), 400'hC3);

        // Decay: two ticks keep the value, the third clears it; reads do not refresh
        applyStimulus(2'b01, 1'b1, 5'h04, 8'hA5, 1'b0);
        setExp(0, 4, 8'hA5);
        checkOutput("decay_regs", regs, expRegs);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("decay_two", 400'(data_out), 400'hA5);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("decay_three", 400'(data_out), 400'h00);
        applyStimulus(2'b10, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("decay_b1", 400'(data_out), 400'h00);
        checkOutput("decay_regs_keep", regs, expRegs);

        // Write on the final decay tick wins and reloads the counter
        applyStimulus(2'b01, 1'b1, 5'h05, 8'h11, 1'b0);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b01, 1'b1, 5'h05, 8'h5A, 1'b1);
        setExp(0, 5, 8'h5A);
        checkOutput("coll_regs", regs, expRegs);
        applyStimulus(2'b01, 1'b0, 5'h1F, 8'h00, 1'b0);
        checkOutput("coll_latch", 400'(data_out), 400'h5A);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b01, 1'b0, 5'h1F, 8'h00, 1'b0);
        checkOutput("coll_reload", 400'(data_out), 400'h5A);
        applyStimulus(2'b00, 1'b0, 5'h00, 8'h00, 1'b1);
        applyStimulus(2'b01, 1'b0, 5'h1F, 8'h00, 1'b0);
        checkOutput("coll_expire", 400'(data_out), 400'h00);

        // Reset mid-decay together with a write
        applyStimulus(2'b01, 1'b1, 5'h06, 8'h77, 1'b0);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b1);
        checkOutput("pre_reset_dout", 400'(data_out), 400'h77);
        reset = 1'b1;
        applyStimulus(2'b01, 1'b1, 5'h00, 8'hEE, 1'b0);
        reset = 1'b0;
        expRegs = '0;
        checkOutput("rst_wr_regs", regs, expRegs);
        checkOutput("rst_wr_dout", 400'(data_out), 400'h00);
        checkOutput("rst_wr_stb", 400'(wr_stb), 400'h0);
        checkOutput("rst_wr_waddr", 400'(wr_addr), 400'h00);
        applyStimulus(2'b01, 1'b0, 5'h1E, 8'h00, 1'b0);
        checkOutput("rst_latch_b0", 400'(data_out), 400'h00);
        applyStimulus(2'b10, 1'b0, 5'h00, 8'h00, 1'b0);
        checkOutput("rst_latch_b1", 400'(data_out), 400'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
